// File: rtl/alu_sequencer.sv
// Micro-sequencer feeding a 4-bit combinational ALU from an 8-slot program store
// and a 4 x 4-bit operand register file; results and flags are written back.
module alu_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int NREGS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [2:0] prog_addr,
  input  logic [8:0] prog_data,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [3:0] reg_wdata,
  output logic [3:0] reg_rdata,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] alu_code,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic [3:0] last_result,
  output logic [3:0] last_flags,
  output logic [2:0] pc
);

  localparam int PW = $clog2(PROG_DEPTH);
  localparam int RW = $clog2(NREGS);
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] LAST_PC = 3'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_prog [PROG_DEPTH];
  logic [3:0] r_regs [NREGS];
  logic [2:0] r_pc;
  logic [2:0] r_code;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_last_result;
  logic [3:0] r_last_flags;

  logic [8:0] w_instr;
  logic [2:0] w_op;
  logic [1:0] w_dst;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic       w_busy;

  // The store is frozen while busy, so the current slot still names dst during EXEC.
  assign w_instr = r_prog[r_pc];
  assign w_op    = w_instr[8:6];
  assign w_dst   = w_instr[5:4];
  assign w_srca  = w_instr[3:2];
  assign w_srcb  = w_instr[1:0];
  assign w_busy  = (r_state == S_FETCH) || (r_state == S_EXEC);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = (w_op == OP_HALT) ? S_DONE : S_EXEC;
      S_EXEC:  w_next = (r_pc == LAST_PC) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_code        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_last_result <= '0;
      r_last_flags  <= '0;
      for (int unsigned i = 0; i < PROG_DEPTH; i++) r_prog[i[PW-1:0]] <= '1;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i[RW-1:0]] <= '0;
    end else begin
      r_state <= w_next;
      if (!w_busy && prog_we) r_prog[prog_addr] <= prog_data;
      if (!w_busy && reg_we) r_regs[reg_addr] <= reg_wdata;
      case (r_state)
        S_IDLE: if (start) r_pc <= '0;
        S_FETCH: begin
          if (w_op != OP_HALT) begin
            r_code <= w_op;
            r_a    <= r_regs[w_srca];
            r_b    <= r_regs[w_srcb];
          end
        end
        S_EXEC: begin
          r_regs[w_dst] <= alu_result;
          r_last_result <= alu_result;
          r_last_flags  <= alu_flags;
          if (r_pc != LAST_PC) r_pc <= r_pc + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign reg_rdata   = r_regs[reg_addr];
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign alu_code    = r_code;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign last_result = r_last_result;
  assign last_flags  = r_last_flags;
  assign pc          = r_pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU closes the loop and a
// program-level reference model predicts registers, flags, timing and ALU operands.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [8:0] prog_data;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [3:0] reg_wdata;
  logic [3:0] reg_rdata;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] alu_code;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic [3:0] alu_flags;
  logic [3:0] last_result;
  logic [3:0] last_flags;
  logic [2:0] pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.PROG_DEPTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .start(start), .busy(busy), .done(done),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .last_result(last_result), .last_flags(last_flags), .pc(pc)
  );

  // Behavioural ALU: returns {N,Z,C,V,result}
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: begin r = {a[2:0], 1'b0}; c = a[3]; end
      3'd3: begin r = {1'b0, a[3:1]}; c = a[0]; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = '0;
    endcase
    return {r[3], (r == 4'd0), c, v, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_code, alu_a, alu_b);

  // Reference model state
  logic [8:0] m_prog [8];
  logic [3:0] m_regs [4];
  logic [3:0] m_last_r;
  logic [3:0] m_last_f;
  int         exp_n;
  int         exp_cycles;
  logic [2:0] exp_pc;
  logic [3:0] exp_a [8];
  logic [3:0] exp_b [8];
  logic [2:0] exp_code [8];

  function automatic logic [8:0] ins(input int op, input int d, input int sa, input int sb);
    return {3'(op), 2'(d), 2'(sa), 2'(sb)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_prog[i] = 9'h1FF;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_last_r = 4'd0;
    m_last_f = 4'd0;
  endtask

  task automatic model_run();
    logic [7:0] res;
    logic [8:0] w;
    bit         halted;
    halted = 0;
    exp_n  = 0;
    exp_pc = 3'd7;
    for (int p = 0; p < 8; p++) begin
      w = m_prog[p];
      if (w[8:6] == 3'b111) begin
        halted = 1;
        exp_pc = 3'(p);
        break;
      end
      exp_code[exp_n] = w[8:6];
      exp_a[exp_n]    = m_regs[w[3:2]];
      exp_b[exp_n]    = m_regs[w[1:0]];
      res = alu_fn(w[8:6], m_regs[w[3:2]], m_regs[w[1:0]]);
      m_regs[w[5:4]] = res[3:0];
      m_last_r = res[3:0];
      m_last_f = res[7:4];
      exp_n++;
    end
    exp_cycles = halted ? 2 * exp_n + 2 : 2 * exp_n + 1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 3'(i); prog_data = m_prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reg_we = 1'b1; reg_addr = 2'(i); reg_wdata = m_regs[i];
      @(negedge clk);
    end
    reg_we = 1'b0;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (pc !== exp_pc) begin errors++; $display("FAIL %s pc got=%0d exp=%0d", name, pc, exp_pc); end
    checks++;
    if (last_result !== m_last_r) begin errors++; $display("FAIL %s last_result got=%h exp=%h", name, last_result, m_last_r); end
    checks++;
    if (last_flags !== m_last_f) begin errors++; $display("FAIL %s last_flags got=%b exp=%b", name, last_flags, m_last_f); end
    for (int i = 0; i < 4; i++) begin
      reg_addr = 2'(i);
      #1;
      checks++;
      if (reg_rdata !== m_regs[i]) begin errors++; $display("FAIL %s reg%0d got=%h exp=%h", name, i, reg_rdata, m_regs[i]); end
    end
  endtask

  task automatic run_prog(input string name, input bit inject_busy, input bit same_cycle_write, input logic [3:0] sw_data);
    int cnt;
    int done_at;
    int k;
    if (same_cycle_write) m_regs[0] = sw_data;
    model_run();
    @(negedge clk);
    start = 1'b1;
    if (same_cycle_write) begin reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = sw_data; end
    cnt = 0;
    done_at = 0;
    while (cnt < 40 && done_at == 0) begin
      @(posedge clk); #1;
      cnt++;
      start = 1'b0; reg_we = 1'b0;
      if (inject_busy && cnt == 2) begin
        reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 4'hA;
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 9'h000; start = 1'b1;
      end
      if (inject_busy && cnt == 3) prog_we = 1'b0;
      k = cnt / 2 - 1;
      if (cnt % 2 == 0 && k < exp_n) begin
        checks++;
        if ({alu_code, alu_a, alu_b} !== {exp_code[k], exp_a[k], exp_b[k]}) begin
          errors++;
          $display("FAIL %s alu_ops[%0d] got=%0d/%h/%h exp=%0d/%h/%h", name, k, alu_code, alu_a, alu_b, exp_code[k], exp_a[k], exp_b[k]);
        end
      end
      checks++;
      if (busy !== (cnt < exp_cycles)) begin errors++; $display("FAIL %s busy@%0d got=%b exp=%b", name, cnt, busy, cnt < exp_cycles); end
      if (done === 1'b1) done_at = cnt;
    end
    checks++;
    if (done_at != exp_cycles) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_at, exp_cycles); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL %s after_done done/busy got=%b%b exp=00", name, done, busy); end
    check_state(name);
  endtask

  task automatic fresh_prog();
    for (int i = 0; i < 8; i++) m_prog[i] = 9'h1FF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, alu_code, alu_a, alu_b, last_result, last_flags, pc} !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b code=%0d a=%h b=%h lr=%h lf=%h pc=%0d exp=all0",
               busy, done, alu_code, alu_a, alu_b, last_result, last_flags, pc);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_pc = 3'd0;
    check_state("reset");
    run_prog("halt_slot0", 0, 0, 4'd0);
  endtask

  task automatic test_add();
    fresh_prog();
    m_regs[0] = 4'd5; m_regs[1] = 4'd9;
    m_prog[0] = ins(0, 2, 0, 1);
    load_all();
    run_prog("add", 0, 0, 4'd0);
    checks++;
    if (last_flags[3:2] !== 2'b10) begin errors++; $display("FAIL add_NZ got=%b exp=10", last_flags[3:2]); end
  endtask

  task automatic test_sub_zero();
    fresh_prog();
    m_regs[0] = 4'd13; m_regs[1] = 4'd13;
    m_prog[0] = ins(1, 3, 0, 1);
    load_all();
    run_prog("sub_zero", 0, 0, 4'd0);
    checks++;
    if (last_flags[2] !== 1'b1) begin errors++; $display("FAIL sub_Z got=%b exp=1", last_flags[2]); end
  endtask

  task automatic test_chain();
    fresh_prog();
    m_regs[0] = 4'd1;
    for (int i = 0; i < 3; i++) m_prog[i] = ins(0, 0, 0, 0);
    load_all();
    run_prog("chain", 0, 0, 4'd0);
    reg_addr = 2'd0; #1;
    checks++;
    if (reg_rdata !== 4'd8) begin errors++; $display("FAIL chain_r0 got=%h exp=8", reg_rdata); end
  endtask

  task automatic test_full_no_halt();
    for (int i = 0; i < 8; i++) m_prog[i] = ins(6, 1, 1, 0);
    m_regs[0] = 4'hF; m_regs[1] = 4'h0;
    load_all();
    run_prog("full8", 0, 0, 4'd0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) m_prog[i] = 9'($urandom_range(0, 511));
      for (int i = 0; i < 4; i++) m_regs[i] = 4'($urandom_range(0, 15));
      load_all();
      run_prog($sformatf("random%0d", it), 0, 0, 4'd0);
    end
  endtask

  task automatic test_busy_ignore();
    fresh_prog();
    m_regs[0] = 4'd3; m_regs[1] = 4'd4;
    m_prog[0] = ins(0, 2, 0, 1);
    m_prog[1] = ins(0, 3, 2, 0);
    m_prog[2] = ins(5, 1, 3, 1);
    load_all();
    run_prog("busy_ignore", 1, 0, 4'd0);
  endtask

  task automatic test_same_cycle_write();
    fresh_prog();
    m_regs[0] = 4'd1;
    m_prog[0] = ins(0, 2, 0, 0);
    load_all();
    run_prog("same_cycle_wr", 0, 1, 4'd7);
    reg_addr = 2'd2; #1;
    checks++;
    if (reg_rdata !== 4'hE) begin errors++; $display("FAIL same_cycle_r2 got=%h exp=e", reg_rdata); end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    int nd;
    fresh_prog();
    m_regs[0] = 4'd2; m_regs[1] = 4'd6;
    m_prog[0] = ins(0, 2, 0, 1);
    load_all();
    model_run();
    model_run();
    d1 = 0; d2 = 0; nd = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cnt = 1; cnt <= 14; cnt++) begin
      @(posedge clk); #1;
      if (cnt == 9) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (d1 == 0) d1 = cnt; else if (d2 == 0) d2 = cnt;
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 4 || d2 != 9 || nd != 2) begin
      errors++;
      $display("FAIL back_to_back dones got=%0d@%0d,%0d exp=2@4,9", nd, d1, d2);
    end
    check_state("back_to_back");
  endtask

  task automatic test_reset_midrun();
    int nd;
    fresh_prog();
    m_regs[0] = 4'd5; m_regs[1] = 4'd1;
    for (int i = 0; i < 4; i++) m_prog[i] = ins(0, 0, 0, 1);
    load_all();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pc, last_result} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b pc=%0d lr=%h exp=0", busy, done, pc, last_result);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_pc = 3'd0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midrun_no_done got=%0d exp=0", nd); end
    check_state("midrun_cleared");
    run_prog("midrun_halt0", 0, 0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; start = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_chain();
    test_full_no_halt();
    test_random();
    test_busy_ignore();
    test_same_cycle_write();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
